// File: rtl/master_arb_port.sv
// master_arb_port: serial arbiter-port master FSM (request, start, end and hold frames).
// Optional grant-wait timeout enabled by defining GRANT_TIMEOUT_EN.
module master_arb_port #(
    parameter int S_ID_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [S_ID_WIDTH-1:0] req_slave_id,
    input  logic                  com_end,
    input  logic                  hold_ack,
    input  logic                  arb_in,
    output logic                  port_out,
    output logic                  ready,
    output logic                  com_active,
    output logic                  preempt_req,
    output logic                  com_done,
    output logic                  timeout_err
);
    localparam int FL = S_ID_WIDTH + 4;
    localparam int CW = $clog2(FL);
    localparam logic [FL-1:0] START_F = {3'b101, {(FL-3){1'b0}}};
    localparam logic [FL-1:0] END_F   = {4'b0110, {(FL-4){1'b0}}};
    localparam logic [FL-1:0] HOLD_F  = {4'b0100, {(FL-4){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, SEND_REQ, WAIT_GRANT, SEND_START, COMM, SEND_END, SEND_HOLD, HELD
    } state_t;

    state_t        state, state_n;
    logic [FL-1:0] tx, tx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pre_n, last;
    logic [1:0]    rx_cnt, rx_code;
    logic          rx_sh, rx_valid;
    logic          grant, preempt, resume, expire;

    // Receiver: 0 hunts for a start bit, 1-2 take code bits, 3 is the decode-valid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_sh    <= 1'b0;
            rx_code  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_cnt   <= rx_cnt == 2'd0 ? {1'b0, arb_in} : rx_cnt + 2'd1;
            rx_sh    <= rx_cnt == 2'd1 ? arb_in : rx_sh;
            rx_valid <= rx_cnt == 2'd2 && (rx_sh || arb_in);
            rx_code  <= rx_cnt == 2'd2 ? {rx_sh, arb_in} : rx_code;
        end
    end

    assign grant   = rx_valid && rx_code == 2'b11;
    assign preempt = rx_valid && rx_code == 2'b10;
    assign resume  = rx_valid && rx_code == 2'b01;

    always_comb begin
        state_n = state;
        tx_n    = tx;
        cnt_n   = cnt;
        pre_n   = preempt_req;
        last    = cnt == '0;
        case (state)
            IDLE: if (req) begin
                state_n = SEND_REQ;
                tx_n    = {3'b111, req_slave_id, 1'b0};
                cnt_n   = CW'(FL - 1);
            end
            SEND_REQ, SEND_START, SEND_END, SEND_HOLD: begin
                state_n = !last ? state :
                          state == SEND_REQ   ? WAIT_GRANT :
                          state == SEND_START ? COMM :
                          state == SEND_END   ? IDLE : HELD;
                tx_n    = tx << 1;
                cnt_n   = last ? cnt : cnt - 1'b1;
            end
            WAIT_GRANT: state_n = grant ? SEND_START : expire ? IDLE : WAIT_GRANT;
            COMM: begin
                if (com_end) begin
                    state_n = SEND_END;
                    tx_n    = END_F;
                    cnt_n   = CW'(3);
                    pre_n   = 1'b0;
                end else if (hold_ack && preempt_req) begin
                    state_n = SEND_HOLD;
                    tx_n    = HOLD_F;
                    cnt_n   = CW'(3);
                    pre_n   = 1'b0;
                end else if (preempt) begin
                    pre_n   = 1'b1;
                end
            end
            HELD: if (grant || resume) state_n = SEND_START;
            default: state_n = IDLE;
        endcase
        if (state_n == SEND_START && state != SEND_START) begin
            tx_n  = START_F;
            cnt_n = CW'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx          <= '0;
            cnt         <= '0;
            port_out    <= 1'b0;
            ready       <= 1'b1;
            com_active  <= 1'b0;
            preempt_req <= 1'b0;
            com_done    <= 1'b0;
        end else begin
            state       <= state_n;
            tx          <= tx_n;
            cnt         <= cnt_n;
            port_out    <= state_n inside {SEND_REQ, SEND_START, SEND_END, SEND_HOLD} ?
                           tx_n[FL-1] : state_n == COMM;
            ready       <= state_n == IDLE;
            com_active  <= state_n == COMM;
            preempt_req <= pre_n;
            com_done    <= state_n == SEND_END && cnt_n == '0;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    assign expire = state == WAIT_GRANT && tcnt == TW'(TIMEOUT_CYCLES - 1);
    // A grant decoded on the expiry cycle wins, so no error is flagged then.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= state == WAIT_GRANT && state_n == WAIT_GRANT ? tcnt + 1'b1 : '0;
            timeout_err <= expire && !grant;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_master_arb_port.sv
// tb_master_arb_port: randomized and directed bench for master_arb_port with a queue-based model.
module tb_master_arb_port;
    localparam int W  = 2;
    localparam int TO = 8;
`ifdef GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    typedef enum int {M_IDLE, M_TX, M_WAIT, M_COMM, M_HELD} mode_t;

    logic clk = 1'b0;
    logic rst, req, com_end, hold_ack, arb_in;
    logic [W-1:0] req_slave_id;
    logic port_out, ready, com_active, preempt_req, com_done, timeout_err;

    int vectors = 0;
    int miscompares = 0;
    mode_t m_mode = M_IDLE;
    mode_t m_after = M_IDLE;
    bit m_q[$];
    bit m_end = 1'b0, m_pre = 1'b0, m_to = 1'b0;
    int m_wait = 0;
    logic n_po, n_rdy, n_act, n_pre, n_done, n_to;
    logic e_po, e_rdy, e_act, e_pre, e_done, e_to;
    bit chk_on = 1'b0;
    bit arb_q[$];
    int code_at[int];
    int cyc = 0;
    int arb_free = 0;
    logic [31:0] po_hist = '0, done_hist = '0;

    always #5 clk = ~clk;

    master_arb_port #(.S_ID_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_slave_id(req_slave_id),
        .com_end(com_end), .hold_ack(hold_ack), .arb_in(arb_in),
        .port_out(port_out), .ready(ready), .com_active(com_active),
        .preempt_req(preempt_req), .com_done(com_done), .timeout_err(timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("port_out", 32'(port_out), 32'(e_po));
            chk("ready", 32'(ready), 32'(e_rdy));
            chk("com_active", 32'(com_active), 32'(e_act));
            chk("preempt_req", 32'(preempt_req), 32'(e_pre));
            chk("com_done", 32'(com_done), 32'(e_done));
            chk("timeout_err", 32'(timeout_err), 32'(e_to));
        end
    end

    function automatic void load(input logic [7:0] pat, input int len, input mode_t after, input bit is_end);
        m_q.delete();
        for (int i = len - 1; i >= 0; i--) m_q.push_back(pat[i]);
        m_mode  = M_TX;
        m_after = after;
        m_end   = is_end;
    endfunction

    // code: 3=GRANT 2=PREEMPT 1=RESUME 0=none, as seen by the master at this edge
    function automatic void model_step(input bit r, input bit q, input logic [W-1:0] id,
                                       input bit ce, input bit ha, input int code);
        m_to = 1'b0;
        if (r) begin
            m_mode = M_IDLE;
            m_q.delete();
            m_pre = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (q) load({2'b00, 3'b111, id, 1'b0}, 6, M_WAIT, 1'b0);
                M_TX: begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_mode = m_after;
                        m_wait = 0;
                    end
                end
                M_WAIT: begin
                    if (code == 3) load(8'b101, 3, M_COMM, 1'b0);
                    else begin
                        m_wait++;
                        if (TO_EN && m_wait == TO) begin
                            m_mode = M_IDLE;
                            m_to = 1'b1;
                        end
                    end
                end
                M_COMM: begin
                    if (ce) begin
                        load(8'b0110, 4, M_IDLE, 1'b1);
                        m_pre = 1'b0;
                    end else if (ha && m_pre) begin
                        load(8'b0100, 4, M_HELD, 1'b0);
                        m_pre = 1'b0;
                    end else if (code == 2) m_pre = 1'b1;
                end
                M_HELD: if (code == 3 || code == 1) load(8'b101, 3, M_COMM, 1'b0);
                default: m_mode = M_IDLE;
            endcase
        end
        n_po   = m_mode == M_TX ? m_q[0] : m_mode == M_COMM;
        n_rdy  = m_mode == M_IDLE;
        n_act  = m_mode == M_COMM;
        n_pre  = m_pre;
        n_done = m_mode == M_TX && m_end && m_q.size() == 1;
        n_to   = m_to;
    endfunction

    task automatic tick(input bit r = 1'b0, input bit q = 1'b0, input logic [W-1:0] id = '0,
                        input bit ce = 1'b0, input bit ha = 1'b0);
        int code;
        rst = r;
        req = q;
        req_slave_id = id;
        com_end = ce;
        hold_ack = ha;
        arb_in = arb_q.size() > 0 ? arb_q.pop_front() : 1'b0;
        code = code_at.exists(cyc) ? code_at[cyc] : 0;
        model_step(r, q, id, ce, ha, code);
        @(posedge clk);
        e_po = n_po; e_rdy = n_rdy; e_act = n_act; e_pre = n_pre; e_done = n_done; e_to = n_to;
        cyc++;
        #1;
        po_hist = {po_hist[30:0], port_out};
        done_hist = {done_hist[30:0], com_done};
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic launch(input int code);
        while (arb_q.size() > 0 || cyc < arb_free) tick();
        arb_q.push_back(1'b1);
        arb_q.push_back(code[1]);
        arb_q.push_back(code[0]);
        if (code != 0) code_at[cyc + 3] = code;
        arb_free = cyc + 4;
    endtask

    task automatic to_comm(input logic [W-1:0] id);
        tick(1'b0, 1'b1, id);
        idle(6);
        launch(3);
        idle(7);
    endtask

    initial begin
        bit r;
        rst = 1'b1; req = 1'b0; req_slave_id = '0; com_end = 1'b0; hold_ack = 1'b0; arb_in = 1'b0;
        tick(1'b1);
        chk_on = 1'b1;
        tick(1'b1);
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst port_out", 32'(port_out), 32'd0);
        chk("rst com_active", 32'(com_active | preempt_req | com_done | timeout_err), 32'd0);

        tick(1'b0, 1'b1, 2'b10);
        chk("req ready", 32'(ready), 32'd0);
        idle(5);
        chk("req frame", 32'(po_hist[5:0]), 32'(6'b111100));

        launch(3);
        idle(7);
        chk("grant frame", 32'(po_hist[6:0]), 32'(7'b0001011));
        chk("grant com_active", 32'(com_active), 32'd1);

        tick(1'b0, 1'b0, '0, 1'b1);
        idle(4);
        chk("end frame", 32'(po_hist[4:0]), 32'(5'b01100));
        chk("end com_done", 32'(done_hist[4:0]), 32'(5'b00010));
        chk("end ready", 32'(ready), 32'd1);

        to_comm(2'b01);
        launch(2);
        idle(4);
        chk("preempt set", 32'(preempt_req), 32'd1);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle(4);
        chk("hold frame", 32'(po_hist[4:0]), 32'(5'b01000));
        chk("hold clears preempt", 32'(preempt_req), 32'd0);
        launch(1);
        idle(7);
        chk("resume frame", 32'(po_hist[3:0]), 32'(4'b1011));
        chk("resume com_active", 32'(com_active), 32'd1);

        launch(2);
        idle(4);
        chk("preempt again", 32'(preempt_req), 32'd1);
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("end beats hold", 32'(preempt_req), 32'd0);
        idle(3);
        chk("end beats hold frame", 32'(po_hist[3:0]), 32'(4'b0110));
        chk("end beats hold done", 32'(com_done), 32'd1);
        tick();

        tick(1'b0, 1'b1, 2'b11);
        idle(2);
        tick(1'b1);
        chk("mid-frame rst port_out", 32'(port_out), 32'd0);
        chk("mid-frame rst ready", 32'(ready), 32'd1);
        tick();
        tick(1'b0, 1'b1, 2'b01);
        idle(5);
        chk("post-rst frame", 32'(po_hist[5:0]), 32'(6'b111010));
        idle(1);
`ifdef GRANT_TIMEOUT_EN
        idle(7);
        chk("timeout early", 32'(timeout_err), 32'd0);
        tick();
        chk("timeout pulse", 32'(timeout_err), 32'd1);
        tick();
        chk("timeout ready", 32'(ready), 32'd1);
        chk("timeout single", 32'(timeout_err), 32'd0);
`else
        idle(30);
        chk("no timeout wait", 32'(ready), 32'd0);
        chk("no timeout err", 32'(timeout_err), 32'd0);
        launch(3);
        idle(7);
        chk("late grant", 32'(com_active), 32'd1);
        tick(1'b0, 1'b0, '0, 1'b1);
        idle(4);
`endif

        for (int i = 0; i < 5000; i++) begin
            r = cyc >= arb_free && $urandom_range(0, 149) == 0;
            if (!r && arb_q.size() == 0 && cyc >= arb_free && $urandom_range(0, 3) == 0)
                launch(int'($urandom_range(0, 3)));
            tick(r, $urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0);
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
